// File: rtl/result_drain_scheduler.sv
// Run sequencer: clears the result FIFO, launches/collects each processor row, then drains the FIFO to the UART.
// Optional macro PROC_WATCHDOG_EN adds a WAIT_PROC watchdog that aborts to DRAIN after TIMEOUT_CYCLES.
module result_drain_scheduler #(
  parameter int unsigned NUM_PROC       = 4,
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned N_WIDTH        = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_WIDTH-1:0]   n_rows,
  input  logic                 proc_done,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic                 tx_ready,
  output logic                 proc_start,
  output logic [SEL_WIDTH-1:0] proc_sel,
  output logic                 fifo_clear,
  output logic                 fifo_push,
  output logic                 fifo_pop,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 clamped,
  output logic                 timeout
);

  localparam int unsigned MAX_ROWS = FIFO_DEPTH / NUM_PROC;
  localparam int unsigned ISS_W    = SEL_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LAUNCH, S_WAIT_PROC, S_COLLECT, S_DRAIN, S_GAP, S_FINISH
  } state_t;

  state_t               r_state, w_next;
  logic [N_WIDTH-1:0]   r_rows, r_row_cnt;
  logic [ISS_W-1:0]     r_issued;
  logic [SEL_WIDTH-1:0] r_sel;
  logic                 r_proc_start, r_fifo_clear, r_push, r_pop;
  logic                 r_busy, r_done, r_clamped, r_timeout;
  logic                 w_push, w_pop, w_latch, w_row_inc, w_timeout_set;
  logic                 w_wd_expired;

`ifdef PROC_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;

  // Counts consecutive WAIT_PROC cycles without proc_done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT_PROC && !proc_done) begin
      r_wd <= r_wd + WD_W'(1);
    end else begin
      r_wd <= '0;
    end
  end

  assign w_wd_expired = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_wd_expired = 1'b0;
`endif

  // Next-state and per-cycle decisions; pushes are decided one edge ahead of the visible pulse
  always_comb begin
    w_next        = r_state;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_latch       = 1'b0;
    w_row_inc     = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch = 1'b1;
          w_next  = S_CLEAR;
        end
      end
      S_CLEAR:  w_next = (r_rows != '0) ? S_LAUNCH : S_FINISH;
      S_LAUNCH: w_next = S_WAIT_PROC;
      S_WAIT_PROC: begin
        if (proc_done) begin
          w_next = S_COLLECT;
          w_push = !fifo_full;
        end else if (w_wd_expired) begin
          w_timeout_set = 1'b1;
          w_next        = S_DRAIN;
        end
      end
      S_COLLECT: w_push = !fifo_full;
      S_DRAIN: begin
        if (fifo_empty) begin
          w_next = S_FINISH;
        end else if (tx_ready) begin
          w_pop  = 1'b1;
          w_next = S_GAP;
        end
      end
      S_GAP:    w_next = S_DRAIN;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_push && r_issued == ISS_W'(NUM_PROC - 1)) begin
      w_row_inc = 1'b1;
      w_next    = (r_row_cnt + N_WIDTH'(1) == r_rows) ? S_DRAIN : S_LAUNCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rows       <= '0;
      r_row_cnt    <= '0;
      r_issued     <= '0;
      r_sel        <= '0;
      r_proc_start <= 1'b0;
      r_fifo_clear <= 1'b0;
      r_push       <= 1'b0;
      r_pop        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_clamped    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_proc_start <= (w_next == S_LAUNCH);
      r_fifo_clear <= (w_next == S_CLEAR);
      r_push       <= w_push;
      r_pop        <= w_pop;
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_FINISH);
      if (w_latch) begin
        r_rows    <= (n_rows > N_WIDTH'(MAX_ROWS)) ? N_WIDTH'(MAX_ROWS) : n_rows;
        r_clamped <= (n_rows > N_WIDTH'(MAX_ROWS));
        r_timeout <= 1'b0;
        r_row_cnt <= '0;
        r_sel     <= '0;
      end else begin
        if (w_timeout_set) r_timeout <= 1'b1;
        if (w_row_inc)     r_row_cnt <= r_row_cnt + N_WIDTH'(1);
        // proc_sel tracks the visible push and advances once that push has been taken
        if (r_push) begin
          r_sel <= (r_sel == SEL_WIDTH'(NUM_PROC - 1)) ? '0 : r_sel + SEL_WIDTH'(1);
        end
      end
      if (r_state == S_LAUNCH) begin
        r_issued <= '0;
      end else if (w_push) begin
        r_issued <= r_issued + ISS_W'(1);
      end
    end
  end

  assign proc_start = r_proc_start;
  assign proc_sel   = r_sel;
  assign fifo_clear = r_fifo_clear;
  assign fifo_push  = r_push;
  assign fifo_pop   = r_pop;
  assign tx_valid   = r_pop;
  assign busy       = r_busy;
  assign done       = r_done;
  assign clamped    = r_clamped;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_result_drain_scheduler.sv
// Directed self-checking bench for result_drain_scheduler with FIFO and processor-array models.
module tb_result_drain_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n_rows = 4'd0;
  logic       proc_done = 1'b0;
  logic       tx_ready = 1'b1;
  logic       fifo_full, fifo_empty;
  logic       proc_start, fifo_clear, fifo_push, fifo_pop, tx_valid;
  logic       busy, done, clamped, timeout;
  logic [1:0] proc_sel;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fcnt = 0;
  logic full_force = 1'b0;

  // monitor-owned bookkeeping
  int n_clear = 0, n_start = 0, n_push = 0, n_pop = 0, n_done = 0, n_bad = 0, n_badgap = 0;
  int last_pop = -1, st_cyc = 0, last_st = 0, done_cyc = 0, pd_cyc = 0, pd_lat = -1, to_cyc = 0;
  int sel_n = 0, launches = 0, pd_cnt = 0, stall_left = 0, stall_obs = 0, stall_bad = 0;
  int sel_log [0:15];
  logic first_st = 1'b0, pd_pend = 1'b0, stall_done = 1'b0, to_prev = 1'b0;

  // initial-owned knobs
  int   hang_row = 0;
  logic stall_en = 1'b0;
  int   t0 = 0;

  assign fifo_full  = (fcnt >= 8) || full_force;
  assign fifo_empty = (fcnt == 0);

  always #5 clk = ~clk;

  result_drain_scheduler #(
    .NUM_PROC(4), .SEL_WIDTH(2), .N_WIDTH(4), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows), .proc_done(proc_done),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .tx_ready(tx_ready),
    .proc_start(proc_start), .proc_sel(proc_sel), .fifo_clear(fifo_clear),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop), .tx_valid(tx_valid), .busy(busy),
    .done(done), .clamped(clamped), .timeout(timeout)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clear) fcnt <= 0;
    else            fcnt <= fcnt + int'(fifo_push) - int'(fifo_pop);
  end

  // Observe outputs mid-cycle, then advance the processor and stall models
  always @(negedge clk) begin
    if (fifo_clear) begin
      n_clear++; first_st = 1'b1; sel_n = 0; launches = 0; last_pop = -1; stall_done = 1'b0;
    end
    if (proc_start) begin
      n_start++; last_st = cyc;
      if (first_st) begin st_cyc = cyc; first_st = 1'b0; end
    end
    if (stall_left > 0) begin
      stall_obs++;
      if (fifo_push || proc_sel != 2'd2) stall_bad++;
      stall_left--;
    end
    if (fifo_push) begin
      n_push++;
      if (sel_n < 16) sel_log[sel_n] = int'(proc_sel);
      sel_n++;
      if (pd_pend) begin pd_lat = cyc - pd_cyc; pd_pend = 1'b0; end
      if (stall_en && !stall_done && proc_sel == 2'd1) begin stall_left = 3; stall_done = 1'b1; end
    end
    if (fifo_pop) begin
      if (last_pop >= 0 && cyc - last_pop != 2) n_badgap++;
      last_pop = cyc; n_pop++;
    end
    if ((fifo_push && fifo_pop) || (tx_valid != fifo_pop)) n_bad++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (timeout && !to_prev) to_cyc = cyc;
    to_prev = timeout;
    full_force = (stall_left > 0);
    if (proc_start) begin
      launches++;
      pd_cnt = (launches == hang_row) ? 0 : 6;
    end else if (pd_cnt > 0) begin
      pd_cnt--;
    end
    proc_done = (pd_cnt == 1);
    if (proc_done) begin pd_cyc = cyc; pd_pend = 1'b1; end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_run(input int rows);
    @(negedge clk);
    t0 = cyc; start = 1'b1; n_rows = 4'(rows);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input int d0);
    for (int i = 0; i < budget && n_done == d0; i++) @(posedge clk);
    check(tag, n_done - d0, 1);
    repeat (3) @(posedge clk);
  endtask

  int b_clear, b_start, b_push, b_pop, b_done, b_gap;
  task automatic snap();
    b_clear = n_clear; b_start = n_start; b_push = n_push;
    b_pop = n_pop; b_done = n_done; b_gap = n_badgap;
  endtask

  function automatic int sel_pack();
    return sel_log[0] + 4 * sel_log[1] + 16 * sel_log[2] + 64 * sel_log[3];
  endfunction

  initial begin
    // reset: all outputs low
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", int'({proc_start, proc_sel, fifo_clear, fifo_push, fifo_pop,
                              tx_valid, busy, done, clamped, timeout}), 0);
    reset = 1'b0;

    // single row, free-running drain
    snap();
    start_run(1);
    wait_done("r1_done", 300, b_done);
    check("r1_clear", n_clear - b_clear, 1);
    check("r1_start", n_start - b_start, 1);
    check("r1_start_lat", st_cyc - t0, 2);
    check("r1_done_lat", pd_lat, 1);
    check("r1_push", n_push - b_push, 4);
    check("r1_sels", sel_pack(), 228);
    check("r1_pop", n_pop - b_pop, 4);
    check("r1_popgap", n_badgap - b_gap, 0);
    check("r1_clamped", int'(clamped), 0);
    check("r1_timeout", int'(timeout), 0);
    check("r1_busy", int'(busy), 0);

    // clamp 5 rows down to 2
    snap();
    start_run(5);
    wait_done("r5_done", 400, b_done);
    check("r5_clamped", int'(clamped), 1);
    check("r5_start", n_start - b_start, 2);
    check("r5_push", n_push - b_push, 8);
    check("r5_pop", n_pop - b_pop, 8);
    check("r5_popgap", n_badgap - b_gap, 0);

    // zero rows
    snap();
    start_run(0);
    wait_done("r0_done", 50, b_done);
    check("r0_clear", n_clear - b_clear, 1);
    check("r0_done_lat", done_cyc - t0, 2);
    check("r0_start", n_start - b_start, 0);
    check("r0_push", n_push - b_push, 0);
    check("r0_pop", n_pop - b_pop, 0);
    check("r0_clamped", int'(clamped), 0);

    // fifo_full stall while proc_sel=2
    snap();
    stall_en = 1'b1;
    start_run(1);
    wait_done("st_done", 300, b_done);
    stall_en = 1'b0;
    check("st_obs", stall_obs, 3);
    check("st_held", stall_bad, 0);
    check("st_push", n_push - b_push, 4);
    check("st_sels", sel_pack(), 228);
    check("st_pop", n_pop - b_pop, 4);

    // UART back-pressure in DRAIN
    snap();
    tx_ready = 1'b0;
    start_run(1);
    for (int i = 0; i < 200 && n_push - b_push < 4; i++) @(posedge clk);
    check("bp_push", n_push - b_push, 4);
    repeat (12) @(posedge clk);
    check("bp_nopop", n_pop - b_pop, 0);
    check("bp_busy", int'(busy), 1);
    @(negedge clk);
    tx_ready = 1'b1;
    wait_done("bp_done", 200, b_done);
    check("bp_pop", n_pop - b_pop, 4);

    // reset mid-COLLECT
    snap();
    start_run(1);
    for (int i = 0; i < 200 && n_push == b_push; i++) @(posedge clk);
    check("rm_inpush", int'(n_push > b_push), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rm_busy", int'(busy), 0);
    check("rm_outs", int'({proc_start, fifo_clear, fifo_push, fifo_pop, done}), 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    check("rm_nodone", n_done - b_done, 0);
    check("rm_nopop", n_pop - b_pop, 0);

`ifdef PROC_WATCHDOG_EN
    // second row hangs; watchdog drains the first row's results
    snap();
    hang_row = 2;
    start_run(2);
    wait_done("wd_done", 400, b_done);
    hang_row = 0;
    check("wd_timeout", int'(timeout), 1);
    check("wd_lat", to_cyc - last_st, 17);
    check("wd_start", n_start - b_start, 2);
    check("wd_push", n_push - b_push, 4);
    check("wd_pop", n_pop - b_pop, 4);
`endif

    check("pushpop_overlap", n_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
